// File: rtl/bmem_responder_if.sv
// 64-bit bmem request/response bundle between a requester (master) and the memory side (slave).
interface bmem_responder_if;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic [63:0] wdata;
  logic        ready;
  logic [31:0] raddr;
  logic [63:0] rdata;
  logic        rvalid;

  modport master (output addr, read, write, wdata, input  ready, raddr, rdata, rvalid);
  modport slave  (input  addr, read, write, wdata, output ready, raddr, rdata, rvalid);
endinterface

// File: rtl/bmem_responder.sv
// Burst-memory responder: 4-beat line writes, queued in-order 4-beat line reads after a fixed latency.
// Optional BMEM_RESP_PROTOCOL_CHECK_EN adds a sticky proto_err output.
module bmem_responder #(
  parameter int LINE_IDX_W   = 8,
  parameter int READ_LATENCY = 4,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  bmem_responder_if.slave bmem
`ifdef BMEM_RESP_PROTOCOL_CHECK_EN
  , output logic proto_err
`endif
);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int NLINES = 1 << LINE_IDX_W;

  typedef enum logic {IDLE, WBURST} wstate_e;

  typedef struct packed {
    logic [255:0]     line;
    logic [26:0]      tag;
    logic [CNT_W-1:0] cnt;
  } rd_entry_t;

  logic [255:0] mem [NLINES];

  wstate_e               state_q, state_d;
  logic [1:0]            wbeat_q, wbeat_d;
  logic [LINE_IDX_W-1:0] widx_q, widx_d;

  rd_entry_t        q_mem [QUEUE_DEPTH];
  rd_entry_t        head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   q_cnt;
  logic [1:0]       rbeat_q;
  logic             run_q;
  logic [63:0]      rdata_q;
  logic [31:0]      raddr_q;

  logic                  q_full, q_empty, rvalid, pop, push, ready, avail, wstart, mem_we;
  logic [LINE_IDX_W-1:0] req_idx, mem_widx;
  logic [1:0]            mem_wword;

  wire unused_addr_lsb = &{1'b0, bmem.addr[4:0]};

  assign req_idx = bmem.addr[5 +: LINE_IDX_W];
  assign head    = q_mem[rd_ptr];
  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == (PTR_W+1)'(QUEUE_DEPTH));
  assign rvalid  = !q_empty && (head.cnt == '0);
  assign pop     = rvalid && (rbeat_q == 2'd3);
  // rst_n is folded in so nothing is accepted on the reset edge itself
  assign avail   = run_q && rst_n;

  always_comb begin
    state_d   = state_q;
    wbeat_d   = wbeat_q;
    widx_d    = widx_q;
    ready     = 1'b0;
    push      = 1'b0;
    wstart    = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = widx_q;
    mem_wword = wbeat_q;
    case (state_q)
      IDLE: begin
        ready = avail && (!q_full || pop);
        if (ready && bmem.write) begin
          wstart    = 1'b1;
          mem_we    = 1'b1;
          mem_widx  = req_idx;
          mem_wword = 2'd0;
          widx_d    = req_idx;
          wbeat_d   = 2'd1;
          state_d   = WBURST;
        end else if (ready && bmem.read) begin
          push = 1'b1;
        end
      end
      WBURST: begin
        ready = avail;
        if (ready && bmem.write) begin
          mem_we  = 1'b1;
          wbeat_d = wbeat_q + 2'd1;
          if (wbeat_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array is never reset: contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx][{mem_wword, 6'd0} +: 64] <= bmem.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wbeat_q <= '0;
      widx_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_cnt   <= '0;
      rbeat_q <= '0;
      run_q   <= 1'b0;
      rdata_q <= '0;
      raddr_q <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      wbeat_q <= wbeat_d;
      widx_q  <= widx_d;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (q_mem[i].cnt != '0) q_mem[i].cnt <= q_mem[i].cnt - 1'b1;
      if (push) begin
        q_mem[wr_ptr] <= '{line: mem[req_idx], tag: bmem.addr[31:5], cnt: CNT_W'(READ_LATENCY - 1)};
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      q_cnt <= q_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (rvalid) begin
        rbeat_q <= rbeat_q + 2'd1;
        rdata_q <= head.line[{rbeat_q, 6'd0} +: 64];
        raddr_q <= {head.tag, 5'b0};
      end
    end
  end

  assign bmem.ready  = ready;
  assign bmem.rvalid = rvalid;
  assign bmem.rdata  = rvalid ? head.line[{rbeat_q, 6'd0} +: 64] : rdata_q;
  assign bmem.raddr  = rvalid ? {head.tag, 5'b0} : raddr_q;

`ifdef BMEM_RESP_PROTOCOL_CHECK_EN
  logic [26:0] wtag_q;
  logic        perr;

  always_comb
    perr = run_q && (((state_q == WBURST) &&
                      (bmem.read || (bmem.write && (bmem.addr[31:5] != wtag_q)))) ||
                     ((state_q == IDLE) && bmem.read && bmem.write));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wtag_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (wstart) wtag_q <= bmem.addr[31:5];
      if (perr) proto_err <= 1'b1;
    end
  end
`endif
endmodule
